// File: rtl/pf_geofence_pkg.sv
// Shared definitions for the geofence checker.
// Provides the default coordinate width and the evaluator state encoding.
package pf_geofence_pkg;

    localparam int COORD_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        SUB,
        MUL_A,
        MUL_B,
        MUL_R,
        CMP,
        DONE
    } state_t;

endpackage

// File: rtl/pf_seq_mult.sv
// Radix-2 shift-add unsigned multiplier, one partial product per cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load a/b and perform the first iteration on this edge
//   a, b       : W-bit unsigned operands (sampled only while start=1)
//   done       : high during the cycle whose closing edge completes the product
//   prod       : 2W-bit product, valid after the edge at which done was high
// A multiplication occupies exactly W consecutive cycles starting with the start cycle.
module pf_seq_mult #(
    parameter int W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             done,
    output logic [2*W-1:0]   prod
);

    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] mcand;
    logic [2*W-1:0] mcand_cur;
    logic [W-1:0]   mplier;
    logic [W-1:0]   mplier_cur;
    logic [2*W-1:0] acc_cur;
    logic [CW-1:0]  rem;
    logic           busy;

    // On the start cycle the operands bypass the registers so that the first
    // partial product is accumulated on the same edge that loads them.
    always_comb begin
        mcand_cur  = start ? {{W{1'b0}}, a} : mcand;
        mplier_cur = start ? b : mplier;
        acc_cur    = start ? '0 : prod;
        done       = start ? (W == 1) : (busy && (rem == CW'(1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            rem  <= '0;
        end else if (start) begin
            busy <= (W > 1);
            rem  <= CW'(W - 1);
        end else if (busy) begin
            busy <= (rem != CW'(1));
            rem  <= rem - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (start || busy) begin
            prod   <= acc_cur + (mplier_cur[0] ? mcand_cur : '0);
            mcand  <= mcand_cur << 1;
            mplier <= mplier_cur >> 1;
        end
    end

endmodule

// File: rtl/pf_geofence_checker.sv
// Sequential geofence evaluator: compares squared distance of a GPS fix from
// the fence centre against radius^2 and latches an emergency halt after
// BREACH_CNT consecutive breaches.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   fence_en          : geofence enable, latched with each accepted fix
//   fix_valid/ready   : fix handshake; ready only while idle
//   fix_lat/lon       : signed fix coordinates
//   fence_lat/lon     : signed fence centre
//   fence_radius      : unsigned radius
//   halt_clr          : pulse clearing emergency_halt and breach_count
//   result_valid      : one-cycle result pulse
//   result_breach     : 1 = fix outside fence, qualified by result_valid
//   emergency_halt    : sticky halt flag
//   breach_count      : consecutive breach count, saturating at BREACH_CNT
module pf_geofence_checker
    import pf_geofence_pkg::*;
#(
    parameter int COORD_W    = COORD_W_DEF,
    parameter int BREACH_CNT = 3,
    parameter int CNT_W      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fence_en,
    input  logic                      fix_valid,
    output logic                      fix_ready,
    input  logic signed [COORD_W-1:0] fix_lat,
    input  logic signed [COORD_W-1:0] fix_lon,
    input  logic signed [COORD_W-1:0] fence_lat,
    input  logic signed [COORD_W-1:0] fence_lon,
    input  logic [COORD_W-1:0]        fence_radius,
    input  logic                      halt_clr,
    output logic                      result_valid,
    output logic                      result_breach,
    output logic                      emergency_halt,
    output logic [CNT_W-1:0]          breach_count
);

    state_t                      state;
    logic signed [COORD_W-1:0]   lat_q, lon_q, flat_q, flon_q;
    logic [COORD_W-1:0]          rad_q;
    logic                        en_q;
    logic [COORD_W:0]            da_w, db_w;
    logic [COORD_W-1:0]          da_q, db_q;
    logic [2*COORD_W-1:0]        sq_a, sq_b;
    logic [2*COORD_W:0]          dist_sum;
    logic                        reject;
    logic                        breach_q;
    logic                        mul_start;
    logic                        mul_done;
    logic [COORD_W-1:0]          mul_op;
    logic [2*COORD_W-1:0]        mul_prod;
    logic                        cnt_hit;

    // Difference computed one bit wider than the operands so that
    // +max minus -min cannot wrap before the magnitude is taken.
    function automatic logic [COORD_W:0] abs_diff(input logic signed [COORD_W-1:0] x,
                                                  input logic signed [COORD_W-1:0] y);
        logic signed [COORD_W:0] d;
        d = {x[COORD_W-1], x} - {y[COORD_W-1], y};
        return d[COORD_W] ? -d : d;
    endfunction

    always_comb begin
        da_w     = abs_diff(lat_q, flat_q);
        db_w     = abs_diff(lon_q, flon_q);
        // Any axis beyond the radius is already outside; this also guarantees
        // da/db fit in COORD_W bits for the multiplier.
        reject   = (da_w > {1'b0, rad_q}) || (db_w > {1'b0, rad_q});
        dist_sum = {1'b0, sq_a} + {1'b0, sq_b};
        cnt_hit  = (breach_count >= CNT_W'(BREACH_CNT - 1));
        case (state)
            MUL_B:   mul_op = db_q;
            MUL_R:   mul_op = rad_q;
            default: mul_op = da_q;
        endcase
    end

    pf_seq_mult #(.W(COORD_W)) u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (mul_op),
        .b     (mul_op),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            fix_ready      <= 1'b1;
            result_valid   <= 1'b0;
            result_breach  <= 1'b0;
            breach_q       <= 1'b0;
            mul_start      <= 1'b0;
            emergency_halt <= 1'b0;
            breach_count   <= '0;
        end else begin
            result_valid <= 1'b0;
            mul_start    <= 1'b0;
            case (state)
                IDLE: begin
                    if (fix_valid) begin
                        state     <= SUB;
                        fix_ready <= 1'b0;
                    end
                end
                SUB: begin
                    if (!en_q) begin
                        breach_q <= 1'b0;
                        state    <= DONE;
                    end else if (reject) begin
                        breach_q <= 1'b1;
                        state    <= DONE;
                    end else begin
                        mul_start <= 1'b1;
                        state     <= MUL_A;
                    end
                end
                MUL_A: begin
                    if (mul_done) begin
                        mul_start <= 1'b1;
                        state     <= MUL_B;
                    end
                end
                MUL_B: begin
                    if (mul_done) begin
                        mul_start <= 1'b1;
                        state     <= MUL_R;
                    end
                end
                MUL_R: begin
                    if (mul_done) begin
                        state <= CMP;
                    end
                end
                CMP: begin
                    // mul_prod holds radius^2; equality counts as inside.
                    breach_q <= (dist_sum > {1'b0, mul_prod});
                    state    <= DONE;
                end
                DONE: begin
                    result_valid  <= 1'b1;
                    result_breach <= breach_q;
                    fix_ready     <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    fix_ready <= 1'b1;
                end
            endcase

            // Counter updates on the edge the result is published. A result
            // that reaches the threshold overrides a simultaneous halt_clr.
            if (state == DONE) begin
                if (breach_q) begin
                    if (cnt_hit) begin
                        emergency_halt <= 1'b1;
                        breach_count   <= CNT_W'(BREACH_CNT);
                    end else if (halt_clr) begin
                        emergency_halt <= 1'b0;
                        breach_count   <= CNT_W'(1);
                    end else begin
                        breach_count   <= breach_count + CNT_W'(1);
                    end
                end else begin
                    breach_count <= '0;
                    if (halt_clr) begin
                        emergency_halt <= 1'b0;
                    end
                end
            end else if (halt_clr) begin
                emergency_halt <= 1'b0;
                breach_count   <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && fix_valid) begin
            lat_q  <= fix_lat;
            lon_q  <= fix_lon;
            flat_q <= fence_lat;
            flon_q <= fence_lon;
            rad_q  <= fence_radius;
            en_q   <= fence_en;
        end
        if (state == SUB) begin
            da_q <= da_w[COORD_W-1:0];
            db_q <= db_w[COORD_W-1:0];
        end
        // Each square is taken on the start cycle of the following multiply.
        if (state == MUL_B && mul_start) begin
            sq_a <= mul_prod;
        end
        if (state == MUL_R && mul_start) begin
            sq_b <= mul_prod;
        end
    end

endmodule
